// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential BCD-to-binary converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Smallest width w with 2**w > 10**digits - 1.
    function automatic int unsigned min_bin_w(input int unsigned digits);
        longint unsigned max_val;
        int unsigned     w;
        max_val = 64'd1;
        w       = 0;
        for (int unsigned i = 0; i < digits; i++) begin
            max_val = max_val * 64'd10;
        end
        max_val = max_val - 64'd1;
        while ((64'd1 << w) <= max_val) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/bcd_to_bin_seq_mul10_add.sv
// Combinational acc*10 + digit built from two shifted copies of acc plus the digit.
module mul10_add #(
    parameter int unsigned BIN_W = 10
) (
    input  logic [BIN_W-1:0] acc_i,
    input  logic [3:0]       digit_i,
    output logic [BIN_W-1:0] result_o
);

    always_comb begin
        result_o = (acc_i << 3) + (acc_i << 1) + BIN_W'(digit_i);
    end

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter: one digit per clock, MSD first, with start/busy/done/err.
module bcd_to_bin_seq
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 3,
    parameter int unsigned BIN_W  = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  err
);

    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DIGITS - 1);

    if (BIN_W < min_bin_w(DIGITS)) begin : g_bad_width
        $error("bcd_to_bin_seq: BIN_W too small for DIGITS");
    end

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [BIN_W-1:0]      acc_q, acc_d;
    logic [4*DIGITS-1:0]   shadow_q, shadow_d;
    logic                  err_pend_q, err_pend_d;
    logic                  done_q, done_d;
    logic [BIN_W-1:0]      bin_q, bin_d;
    logic                  err_q, err_d;

    logic [3:0]            digit;
    logic                  bad_nibble;
    logic [BIN_W-1:0]      acc_next;

    mul10_add #(.BIN_W(BIN_W)) u_mul10 (
        .acc_i    (acc_q),
        .digit_i  (digit),
        .result_o (acc_next)
    );

    always_comb begin
        digit      = '0;
        bad_nibble = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (bcd_in[4*i +: 4] > BCD_MAX) begin
                bad_nibble = 1'b1;
            end
            if (idx_q == IDX_W'(i)) begin
                digit = shadow_q[4*i +: 4];
            end
        end
    end

    // done/bin_out/err are registered on the DONE->IDLE edge, so the pulse lands one cycle after DONE.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        acc_d      = acc_q;
        shadow_d   = shadow_q;
        err_pend_d = err_pend_q;
        done_d     = 1'b0;
        bin_d      = bin_q;
        err_d      = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    shadow_d   = bcd_in;
                    idx_d      = IDX_MAX;
                    acc_d      = '0;
                    err_pend_d = bad_nibble;
                    state_d    = bad_nibble ? DONE : RUN;
                end
            end
            RUN: begin
                acc_d = acc_next;
                if (idx_q == '0) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                bin_d   = err_pend_q ? '0 : acc_q;
                err_d   = err_pend_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= IDX_MAX;
            acc_q      <= '0;
            shadow_q   <= '0;
            err_pend_q <= 1'b0;
            done_q     <= 1'b0;
            bin_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            acc_q      <= acc_d;
            shadow_q   <= shadow_d;
            err_pend_q <= err_pend_d;
            done_q     <= done_d;
            bin_q      <= bin_d;
            err_q      <= err_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign bin_out = bin_q;
    assign err     = err_q;

endmodule
